spi_nibble_rx: RTL and testbench
================================

// Module: spi_nibble_rx
// PURPOSE
//  SPI slave receiver (mode 0) that sits directly upstream of the 7-bit segment decoder.
//  Oversamples SCK/CS_N/MOSI on the system clock and assembles each frame into a DATA_W-bit word.
//  Holds the last good word on data_out; for DATA_W=4, data_out[3:0] drives decoder inputs A,B,C,D.
//  Shifts the previously received word back out on MISO for link check by the master.
// PARAMETERS
//  DATA_W       4  bits per frame; received MSB first
//  SYNC_STAGES  2  flip-flops in each SCK/CS_N/MOSI synchroniser (min 2)
// PORTS
//  clk         in   1       system clock; all logic is on the rising edge
//  rst_n       in   1       asynchronous active-low reset
//  sclk        in   1       SPI clock from master, asynchronous to clk
//  cs_n        in   1       SPI chip select, active low, asynchronous
//  mosi        in   1       SPI data in, asynchronous
//  miso        out  1       SPI data out; 0 while cs_n is high
//  data_out    out  DATA_W  last complete word; held between frames
//  data_valid  out  1       1-clk pulse when data_out updates
//  frame_err   out  1       1-clk pulse: cs_n rose with 0 < bit count < DATA_W
//  overrun     out  1       1-clk pulse: extra SCK rise after DATA_W bits in the same frame
// BEHAVIOUR
//  Reset: all outputs are 0 and the FSM is IDLE; bit_cnt=0, shift_reg=0, echo_reg=0.
//  Reset is asynchronous and may assert mid-frame: the partial frame is dropped, no pulse is issued.
//  Sync: sclk, cs_n and mosi each pass through SYNC_STAGES flops; edges are detected on synced values.
//  - sck_rise = synced sclk 0->1, sck_fall = 1->0. mosi is sampled from its synced copy on sck_rise.
//  - The master must keep SCK high and low for at least SYNC_STAGES+2 clk each; faster SCK is unsupported.
//  FSM states: IDLE, RECV, HOLD.
//  - IDLE: wait for synced cs_n=0, then go to RECV. On entry to RECV, bit_cnt=0 and echo_reg is loaded into the MISO shifter.
//  - RECV: on sck_rise, shift_reg <= {shift_reg[DATA_W-2:0], mosi} and bit_cnt++.
//    After the DATA_W-th bit, the next clk sets data_out <= shift_reg, echo_reg <= shift_reg and data_valid=1 for one clk; then go to HOLD.
//    If synced cs_n=1 with 0 < bit_cnt < DATA_W: frame_err=1 for one clk, data_out is unchanged, go to IDLE.
//    If synced cs_n=1 with bit_cnt=0: go to IDLE silently.
//  - HOLD: each sck_rise gives overrun=1 for one clk; those bits are discarded. Synced cs_n=1 goes to IDLE.
//  - A cs_n rise in the same clk as the completing sck_rise still completes the word, with no frame_err.
//  MISO: mode 0. Bit DATA_W-1 of echo_reg is driven from the first clk of RECV.
//  - Each sck_fall shifts out the next bit. After DATA_W bits, or while not in RECV, miso=0.
//  Latency: the final SCK rise at the pin causes data_valid SYNC_STAGES+2 clk later.
//  bit_cnt width is clog2(DATA_W+1). The counter saturates at DATA_W and never wraps.
//  Back-to-back frames need cs_n high for at least SYNC_STAGES+1 clk, so that IDLE is observed.
// TESTING
//  1 Frame 1,0,1,1 with SCK = 10 clk period -> data_out=4'hB, data_valid pulses once, SYNC_STAGES+2 clk after the last SCK rise.
//  2 Send 4'hB, then 4'h6 -> MISO during the second frame is 1,0,1,1; data_out=4'h6.
//  3 Two bits (1,1), then cs_n high -> frame_err one pulse, data_out stays 4'hB, no data_valid.
//  4 Six SCK rises in one CS with bits 0,1,0,1,1,1 -> data_out=4'h5, overrun pulses twice, one data_valid.
//  5 rst_n low after 3 bits, release, full frame 4'h3 -> all outputs 0 during reset; data_out=4'h3, no frame_err.
//  6 cs_n rises in the same clk as the 4th synced SCK rise of 4'hF -> data_out=4'hF, data_valid=1, frame_err=0.

Source files
------------

// File: rtl/spi_nibble_rx.sv
// ---------------------------------------------------------------------------
// spi_nibble_rx
//   SPI mode-0 slave receiver. SCK, CS_N and MOSI are oversampled on clk
//   through SYNC_STAGES-deep synchronisers. Each frame is assembled MSB first
//   into a DATA_W-bit word, and the last complete word is held on data_out.
//   The previously received word is shifted back out on MISO so the master
//   can check the link.
//
// Ports
//   clk         in   1       system clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   sclk        in   1       SPI clock from master (asynchronous)
//   cs_n        in   1       SPI chip select, active low (asynchronous)
//   mosi        in   1       SPI data in (asynchronous)
//   miso        out  1       SPI data out, 0 outside an active receive
//   data_out    out  DATA_W  last complete word, held between frames
//   data_valid  out  1       one-clk pulse when data_out updates
//   frame_err   out  1       one-clk pulse: frame ended with a partial word
//   overrun     out  1       one-clk pulse: extra SCK rise after a full word
// ---------------------------------------------------------------------------
module spi_nibble_rx #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;

    state_e                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-1:0]      shift_q;
    logic [DATA_W-1:0]      echo_q;
    logic [DATA_W-1:0]      tx_sh_q;
    logic [DATA_W-1:0]      data_out_q;
    logic                   data_valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;

    logic sclk_s, cs_s, mosi_s;
    logic sck_rise, sck_fall;

    // Chip-select chain resets to the inactive level so that reset release
    // does not look like the start of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sclk_s & ~sclk_prev_q;
    assign sck_fall = ~sclk_s & sclk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            echo_q       <= '0;
            tx_sh_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!cs_s) begin
                        state_q   <= RECV;
                        bit_cnt_q <= '0;
                        tx_sh_q   <= echo_q;
                    end
                end
                RECV: begin
                    // A completed word takes priority over cs_n, so a cs_n
                    // rise coincident with the last SCK rise still commits.
                    if (bit_cnt_q == FULL) begin
                        data_out_q   <= shift_q;
                        echo_q       <= shift_q;
                        data_valid_q <= 1'b1;
                        tx_sh_q      <= '0;
                        state_q      <= HOLD;
                    end else if (sck_rise) begin
                        shift_q   <= {shift_q[DATA_W-2:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end else if (cs_s) begin
                        frame_err_q <= (bit_cnt_q != '0);
                        tx_sh_q     <= '0;
                        state_q     <= IDLE;
                    end else if (sck_fall) begin
                        // Zeros shift in behind the echo word, so MISO
                        // drops to 0 once all DATA_W bits have gone out.
                        tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
                    end
                end
                HOLD: begin
                    if (sck_rise) begin
                        overrun_q <= 1'b1;
                    end
                    if (cs_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign miso       = tx_sh_q[DATA_W-1];
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spi_nibble_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_nibble_rx
//   Self-checking bench for spi_nibble_rx: a table of directed frames, a
//   mid-frame reset sequence, then random frames checked against a
//   frame-level reference model.
// ---------------------------------------------------------------------------
module tb_spi_nibble_rx;

    localparam int unsigned DW   = 4;
    localparam int unsigned SS   = 2;
    localparam int          HALF = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk  = 1'b0;
    logic          cs_n  = 1'b1;
    logic          mosi  = 1'b0;
    logic          miso;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nvalid = 0;
    int nferr = 0;
    int novr = 0;
    int valid_cyc = 0;
    int rise_cyc = 0;

    spi_nibble_rx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            nvalid    = nvalid + 1;
            valid_cyc = cyc;
        end
        if (frame_err) nferr = nferr + 1;
        if (overrun)   novr  = novr + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

    typedef struct {
        int         n;
        logic [7:0] bits;
        bit         cs_last;
        logic [3:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
        int         exp_ovr;
        logic [7:0] exp_miso;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit cs_up, inout logic [7:0] ms);
        mosi = b;
        wait_clk(HALF);
        ms = {ms[6:0], miso};
        sclk = 1'b1;
        rise_cyc = cyc;
        if (cs_up) cs_n = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    task automatic run_frame(input int n, input logic [7:0] bits, input bit cs_last,
                             output logic [7:0] ms);
        logic [7:0] m;
        m = '0;
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < n; i++)
            send_bit(bits[n-1-i], cs_last && (i == n - 1), m);
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(8);
        ms = m;
    endtask

    task automatic check_frame(input string tag, input logic [3:0] exp_data,
                               input int dv, input int df, input int dov,
                               input int ev, input int ef, input int eo,
                               input logic [7:0] ms, input logic [7:0] em);
        check({tag, "_data"},  32'(data_out), 32'(exp_data));
        check({tag, "_valid"}, 32'(dv),  32'(ev));
        check({tag, "_ferr"},  32'(df),  32'(ef));
        check({tag, "_ovr"},   32'(dov), 32'(eo));
        check({tag, "_miso"},  32'(ms),  32'(em));
    endtask

    initial begin
        vec_t       vecs[5];
        logic [7:0] ms;
        logic [7:0] bits;
        logic [7:0] em;
        logic [3:0] model_data;
        logic [3:0] model_echo;
        logic [3:0] w;
        logic       sent[$];
        int         v0, f0, o0, n, ev, ef, eo;

        // Directed frames; each entry builds on the state left by the previous one.
        vecs[0] = '{4, 8'b1011,   1'b0, 4'hB, 1, 0, 0, 8'h00};
        vecs[1] = '{2, 8'b11,     1'b0, 4'hB, 0, 1, 0, 8'h02};
        vecs[2] = '{4, 8'b0110,   1'b0, 4'h6, 1, 0, 0, 8'h0B};
        vecs[3] = '{6, 8'b010111, 1'b0, 4'h5, 1, 0, 2, 8'h18};
        vecs[4] = '{4, 8'b1111,   1'b1, 4'hF, 1, 0, 0, 8'h05};

        rst_n = 1'b0;
        wait_clk(3);
        check("reset_outputs", 32'({miso, data_out, data_valid, frame_err, overrun}), 32'h0);
        rst_n = 1'b1;
        wait_clk(4);

        for (int i = 0; i < 5; i++) begin
            v0 = nvalid; f0 = nferr; o0 = novr;
            run_frame(vecs[i].n, vecs[i].bits, vecs[i].cs_last, ms);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_data,
                        nvalid - v0, nferr - f0, novr - o0,
                        vecs[i].exp_valid, vecs[i].exp_ferr, vecs[i].exp_ovr,
                        ms, vecs[i].exp_miso);
            if (i == 0)
                check("latency", 32'(valid_cyc - rise_cyc), 32'(SS + 2));
        end

        // Reset in the middle of a frame: partial word dropped, no pulses.
        v0 = nvalid; f0 = nferr; o0 = novr;
        ms = '0;
        cs_n = 1'b0;
        wait_clk(6);
        send_bit(1'b1, 1'b0, ms);
        send_bit(1'b0, 1'b0, ms);
        send_bit(1'b1, 1'b0, ms);
        rst_n = 1'b0;
        wait_clk(2);
        check("midreset_outputs", 32'({miso, data_out, data_valid, frame_err, overrun}), 32'h0);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(8);
        run_frame(4, 8'b0011, 1'b0, ms);
        check_frame("rst_frame", 4'h3, nvalid - v0, nferr - f0, novr - o0,
                    1, 0, 0, ms, 8'h00);

        // Random frames against a frame-level model.
        model_data = 4'h3;
        model_echo = 4'h3;
        for (int k = 0; k < 24; k++) begin
            n    = int'($urandom_range(0, 6));
            bits = 8'($urandom);
            sent.delete();
            for (int i = 0; i < n; i++) sent.push_back(bits[n-1-i]);
            em = '0;
            for (int i = 0; i < n; i++)
                em = {em[6:0], (i < int'(DW)) ? model_echo[DW-1-i] : 1'b0};
            ev = 0; ef = 0; eo = 0;
            if (n >= int'(DW)) begin
                w = '0;
                for (int i = 0; i < int'(DW); i++) w = {w[2:0], sent[i]};
                model_data = w;
                model_echo = w;
                ev = 1;
                eo = n - int'(DW);
            end else if (n > 0) begin
                ef = 1;
            end
            v0 = nvalid; f0 = nferr; o0 = novr;
            run_frame(n, bits, 1'b0, ms);
            check_frame($sformatf("rnd%0d_n%0d", k, n), model_data,
                        nvalid - v0, nferr - f0, novr - o0,
                        ev, ef, eo, ms, em);
            if (n == int'(DW))
                check($sformatf("rnd%0d_latency", k), 32'(valid_cyc - rise_cyc), 32'(SS + 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
